sb_spram256ka: RTL and testbench



---
 rtl/sb_spram256ka_pkg.sv | 35 +++
 rtl/sb_spram256ka_if.sv | 25 ++
 rtl/sb_spram256ka.sv | 41 ++++
 tb/tb_sb_spram256ka.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sb_spram256ka_pkg.sv
// Shared SPRAM geometry and access decode, used by the SPRAM model and the data cache.
package sb_spram256ka_pkg;

    localparam int SPRAM_ADDR_W    = 14;
    localparam int SPRAM_DATA_W    = 16;
    localparam int SPRAM_DEPTH     = 16384;
    localparam int SPRAM_NIB_LANES = 4;

    typedef logic [SPRAM_ADDR_W-1:0]    spram_addr_t;
    typedef logic [SPRAM_DATA_W-1:0]    spram_data_t;
    typedef logic [SPRAM_NIB_LANES-1:0] spram_mask_t;

    // What one clock edge does to the output register and the array.
    typedef enum logic [1:0] {
        OP_CLEAR,
        OP_HOLD,
        OP_WRITE,
        OP_READ
    } spram_op_t;

    // Power controls dominate the access enables; reset is handled by the caller.
    function automatic spram_op_t spram_decode(
        input logic poweroff,
        input logic sleep,
        input logic standby,
        input logic chipselect,
        input logic wren
    );
        if (!poweroff || sleep)     return OP_CLEAR;
        if (standby || !chipselect) return OP_HOLD;
        if (wren)                   return OP_WRITE;
        return OP_READ;
    endfunction

endpackage

// File: rtl/sb_spram256ka_if.sv
// Access bus of the SPRAM: address, data, enables, power controls and registered read data.
interface sb_spram256ka_if;
    import sb_spram256ka_pkg::*;

    spram_addr_t ADDRESS;
    spram_data_t DATAIN;
    spram_mask_t MASKWREN;
    logic        WREN;
    logic        CHIPSELECT;
    logic        STANDBY;
    logic        SLEEP;
    logic        POWEROFF;
    spram_data_t DATAOUT;

    modport master (
        output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
        input  DATAOUT
    );

    modport slave (
        input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
        output DATAOUT
    );

endinterface

// File: rtl/sb_spram256ka.sv
// Behavioural iCE40UP SPRAM: 16384 x 16 single-port RAM, nibble write enables, registered read.
module sb_spram256ka
    import sb_spram256ka_pkg::*;
(
    input  logic            CLOCK,
    input  logic            RESET_N,
    sb_spram256ka_if.slave  bus
);

    spram_data_t mem [SPRAM_DEPTH];
    spram_data_t dout;
    spram_op_t   op;

    assign op          = spram_decode(bus.POWEROFF, bus.SLEEP, bus.STANDBY,
                                      bus.CHIPSELECT, bus.WREN);
    assign bus.DATAOUT = dout;

    // NOTE: the array is deliberately left out of reset so it maps onto the hard RAM;
    // only the output register is cleared, and array contents survive RESET_N.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            dout <= '0;
        end else begin
            unique case (op)
                OP_CLEAR: dout <= '0;
                OP_HOLD:  dout <= dout;
                OP_WRITE: begin
                    // A write never touches dout: there is no read-during-write bypass.
                    for (int i = 0; i < SPRAM_NIB_LANES; i++) begin
                        if (bus.MASKWREN[i]) begin
                            mem[bus.ADDRESS][4*i +: 4] <= bus.DATAIN[4*i +: 4];
                        end
                    end
                end
                OP_READ:  dout <= mem[bus.ADDRESS];
                default:  dout <= dout;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_spram256ka.sv
// Self-checking bench for sb_spram256ka: directed vector table, hand sequences, randomized model run.
module tb_sb_spram256ka;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sb_spram256ka_if bus ();

    sb_spram256ka dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic [13:0] addr;
        logic [15:0] din;
        logic [3:0]  mask;
        logic        wren;
        logic        cs;
        logic        stby;
        logic        slp;
        logic        pwr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model state for the randomized phase.
    logic [15:0] m_mem [int];
    logic [15:0] m_exp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [13:0] a, input logic [15:0] d,
                                input logic [3:0] m, input logic w, input logic cs,
                                input logic stby, input logic slp, input logic [15:0] e);
        vec_t v;
        v.rst_n = r;   v.addr = a;  v.din = d;   v.mask = m;   v.wren = w;
        v.cs    = cs;  v.stby = stby; v.slp = slp; v.pwr = 1'b1; v.exp = e;
        return v;
    endfunction

    // Present inputs, then advance one rising edge and settle before sampling.
    task automatic drive(input vec_t v);
        rst_n          = v.rst_n;
        bus.ADDRESS    = v.addr;
        bus.DATAIN     = v.din;
        bus.MASKWREN   = v.mask;
        bus.WREN       = v.wren;
        bus.CHIPSELECT = v.cs;
        bus.STANDBY    = v.stby;
        bus.SLEEP      = v.slp;
        bus.POWEROFF   = v.pwr;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        return mk(1'b1, a, d, m, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    endfunction

    function automatic vec_t rd(input logic [13:0] a);
        return mk(1'b1, a, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    endfunction

    // Spec-level behaviour of one edge, using whole-word mask arithmetic.
    task automatic model_step(input vec_t v);
        logic [15:0] bits;
        int          a;
        a    = int'(v.addr);
        bits = 16'h0;
        for (int i = 0; i < 4; i++) if (v.mask[i]) bits = bits | (16'hF << (4 * i));
        if (!v.rst_n || !v.pwr || v.slp) m_exp = 16'h0;
        else if (v.stby || !v.cs)        m_exp = m_exp;
        else if (v.wren)                 m_mem[a] = (m_mem[a] & ~bits) | (v.din & bits);
        else                             m_exp = m_mem[a];
    endtask

    initial begin
        vec_t        v;
        logic [15:0] prev;
        logic [15:0] val;
        n_checks = 0;
        n_errors = 0;

        // Directed table: {rst_n, addr, din, mask, wren, cs, stby, slp, expected DATAOUT}
        tbl.push_back(mk(0, 14'h0000, 16'h0000, 4'h0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 14'h0000, 16'h0000, 4'h0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h0005, 16'hBEEF, 4'hF, 1, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h0005, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hBEEF));
        tbl.push_back(mk(0, 14'h0005, 16'h0000, 4'h0, 0, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 14'h0005, 16'h0000, 4'h0, 0, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h0010, 16'hA5C3, 4'hF, 1, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h3FFF, 16'h1234, 4'hF, 1, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h3FFF, 16'hABCD, 4'h5, 1, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h3FFF, 16'h0000, 4'hF, 0, 1, 0, 0, 16'h1B3D));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'hF, 1, 0, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 16'h1B3D));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'hF, 1, 1, 1, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 1, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'hF, 1, 1, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(0, 14'h0010, 16'hFFFF, 4'hF, 1, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 1, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 0, 0, 16'hA5C3));
        tbl.push_back(mk(1, 14'h0010, 16'h0000, 4'h0, 0, 1, 1, 1, 16'h0000));
        tbl.push_back(mk(1, 14'h3FFF, 16'h0000, 4'h0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 14'h3FFF, 16'h0000, 4'h0, 0, 1, 0, 0, 16'h1B3D));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check($sformatf("vec%0d", i), bus.DATAOUT, tbl[i].exp);
        end

        // Back-to-back write/read on 0..15: writes hold DATAOUT, reads land one edge later.
        drive(rd(14'h0010));
        prev = 16'hA5C3;
        check("b2b_pre", bus.DATAOUT, prev);
        for (int a = 0; a < 16; a++) begin
            val = 16'(a) * 16'h1111;
            drive(wr(14'(a), val, 4'hF));
            check($sformatf("b2b_wr%0d", a), bus.DATAOUT, prev);
            drive(rd(14'(a)));
            check($sformatf("b2b_rd%0d", a), bus.DATAOUT, val);
            prev = val;
        end

        // Power-off clears the output; a rewritten location reads back normally.
        v = rd(14'h0003);
        v.pwr = 1'b0;
        drive(v);
        check("poweroff_clear", bus.DATAOUT, 16'h0000);
        drive(wr(14'h0003, 16'h7E57, 4'hF));
        check("poweroff_wr_hold", bus.DATAOUT, 16'h0000);
        drive(rd(14'h0003));
        check("poweroff_reread", bus.DATAOUT, 16'h7E57);

        // Randomized run against the reference model on a small address pool.
        v = rd(14'h0100);
        v.rst_n = 1'b0;
        drive(v);
        model_step(v);
        for (int a = 0; a < 16; a++) begin
            v = wr(14'h0100 + 14'(a), 16'($urandom), 4'hF);
            drive(v);
            model_step(v);
            check("rnd_init", bus.DATAOUT, m_exp);
        end
        for (int n = 0; n < 400; n++) begin
            v = mk(1'b1, 14'h0100 + 14'($urandom_range(0, 15)), 16'($urandom),
                   4'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, 16'h0);
            v.rst_n = ($urandom_range(0, 19) != 0);
            v.cs    = ($urandom_range(0, 9) != 0);
            v.stby  = ($urandom_range(0, 19) == 0);
            v.slp   = ($urandom_range(0, 19) == 0);
            drive(v);
            model_step(v);
            check($sformatf("rnd%0d", n), bus.DATAOUT, m_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
